// File: rtl/fifo_rd_prefetch.sv
// ---------------------------------------------------------------------------
// fifo_rd_prefetch
//
// Read-side output stage of the async FIFO, in the rclk domain. It sits
// directly after the read-pointer block. It pops words ahead of the consumer
// into a 2-entry registered buffer (head H, skid S). It then presents them as
// a first-word-fall-through valid/ready stream.
//
// The pop request (rinc) depends only on rempty and local state. Consumer
// ready therefore never reaches the pointer increment combinationally. The
// skid entry still lets the stage sustain one word per cycle.
//
// Optional build macro:
//   FIFO_RD_PF_STALL_CNT_EN - adds the stall_cnt output. The counter is a
//                             saturating count of cycles in which a valid
//                             word waited on an unready consumer.
//
// Parameters:
//   DATA_W  width of FIFO words and dout
//   CNT_W   width of the optional stall counter
//
// Ports:
//   rclk        in   read-domain clock
//   rrst        in   asynchronous active-low reset
//   rempty      in   FIFO empty flag from the read-pointer block
//   rdata       in   memory word at the current read address (valid when !rempty)
//   rinc        out  pop request to the read-pointer block
//   dout        out  head word to the consumer
//   dout_valid  out  dout holds a valid word
//   dout_ready  in   consumer accepts dout this cycle
//   occ         out  buffer occupancy, 0..2
//   stall_cnt   out  stall cycle counter (FIFO_RD_PF_STALL_CNT_EN only)
// ---------------------------------------------------------------------------
module fifo_rd_prefetch #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              rempty,
    input  logic [DATA_W-1:0] rdata,
    output logic              rinc,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [1:0]        occ
`ifdef FIFO_RD_PF_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    // The state encoding equals the occupancy, so occ is the state register itself.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("fifo_rd_prefetch: CNT_W must be at least 1");
    end

    logic [1:0]        st, st_nxt;
    logic [DATA_W-1:0] h, h_nxt;
    logic [DATA_W-1:0] s, s_nxt;
    logic              push, pop;

    // rrst gates rinc so that no pop is requested while the stage is held in
    // reset, even when rempty is already low.
    assign rinc       = rrst && !rempty && (st != ST_FULL);
    assign push       = rinc;
    assign dout_valid = (st != ST_EMPTY);
    assign pop        = dout_valid && dout_ready;
    assign dout       = h;
    assign occ        = st;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        st_nxt = st;
        h_nxt  = h;
        s_nxt  = s;
        case (st)
            ST_EMPTY: begin
                if (push) begin
                    h_nxt  = rdata;
                    st_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    s_nxt  = rdata;
                    st_nxt = ST_FULL;
                end else if (push && pop) begin
                    // Full-throughput case: the head is replaced in place.
                    h_nxt  = rdata;
                end else if (pop) begin
                    st_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // rinc is low in FULL, so only a pop can happen here.
                if (pop) begin
                    h_nxt  = s;
                    st_nxt = ST_ONE;
                end
            end
            default: st_nxt = ST_EMPTY;
        endcase
    end

    // NOTE: H and S are plain data registers, but they are reset anyway so that dout reads 0 after reset and no stale skid word can resurface.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            st <= ST_EMPTY;
            h  <= '0;
            s  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
            st <= st_nxt;
            h  <= h_nxt;
            s  <= s_nxt;
        end
    end

`ifdef FIFO_RD_PF_STALL_CNT_EN
    // Counts cycles in which a valid word waits on the consumer. The count
    // saturates at all-ones instead of wrapping.
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            stall_cnt <= '0;
        end else if (dout_valid && !dout_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_prefetch
//
// Directed bench for fifo_rd_prefetch.
//
// A table of per-cycle vectors covers three sequences: a single word,
// back-pressure, and streaming. Each vector gives {rempty, rdata, dout_ready}
// as inputs. It also gives the expected pre-edge rinc and the post-edge
// dout_valid, dout and occ.
//
// Hand-written sequences cover reset behaviour, asynchronous reset while the
// buffer is full, and (with FIFO_RD_PF_STALL_CNT_EN) the stall counter and
// its saturation.
// ---------------------------------------------------------------------------
module tb_fifo_rd_prefetch;

    localparam int DATA_W = 8;

    logic              rclk = 1'b0;
    logic              rrst;
    logic              rempty;
    logic [DATA_W-1:0] rdata;
    logic              rinc;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic [1:0]        occ;
`ifdef FIFO_RD_PF_STALL_CNT_EN
    logic [15:0]       stall_cnt;
    logic              rinc2;
    logic [DATA_W-1:0] dout2;
    logic              dout_valid2;
    logic [1:0]        occ2;
    logic [1:0]        stall_cnt2;
`endif

    int checks = 0;
    int passes = 0;

    always #5 rclk = ~rclk;

    fifo_rd_prefetch #(.DATA_W(DATA_W), .CNT_W(16)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rempty     (rempty),
        .rdata      (rdata),
        .rinc       (rinc),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .occ        (occ)
`ifdef FIFO_RD_PF_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

`ifdef FIFO_RD_PF_STALL_CNT_EN
    fifo_rd_prefetch #(.DATA_W(DATA_W), .CNT_W(2)) dut2 (
        .rclk       (rclk),
        .rrst       (rrst),
        .rempty     (rempty),
        .rdata      (rdata),
        .rinc       (rinc2),
        .dout       (dout2),
        .dout_valid (dout_valid2),
        .dout_ready (dout_ready),
        .occ        (occ2),
        .stall_cnt  (stall_cnt2)
    );
`endif

    typedef struct {
        logic              rempty;
        logic [DATA_W-1:0] rdata;
        logic              rdy;
        logic              exp_rinc;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_dout;
        logic [1:0]        exp_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic re, input logic [DATA_W-1:0] rd, input logic rdy,
                                input logic e_rinc, input logic e_valid,
                                input logic [DATA_W-1:0] e_dout, input logic [1:0] e_occ);
        vec_t v;
        v.rempty    = re;
        v.rdata     = rd;
        v.rdy       = rdy;
        v.exp_rinc  = e_rinc;
        v.exp_valid = e_valid;
        v.exp_dout  = e_dout;
        v.exp_occ   = e_occ;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            passes++;
    endtask

    // Apply inputs, advance one edge, and sample 1 ns after the edge.
    task automatic cycle();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with data already waiting: nothing may be popped or shown.
        rrst       = 1'b0;
        rempty     = 1'b0;
        rdata      = 8'hA5;
        dout_ready = 1'b0;
        #12;
        check("rst rinc",  32'(rinc), 32'd0);
        check("rst valid", 32'(dout_valid), 32'd0);
        check("rst occ",   32'(occ), 32'd0);
        check("rst dout",  32'(dout), 32'h00);

        // Release away from the edge. rinc rises before the next edge.
        @(negedge rclk);
        rrst = 1'b1;
        #1;
        check("post-rst rinc", 32'(rinc), 32'd1);
        cycle();
        check("first word dout",  32'(dout), 32'hA5);
        check("first word valid", 32'(dout_valid), 32'd1);
        check("first word occ",   32'(occ), 32'd1);
        rempty     = 1'b1;
        dout_ready = 1'b1;
        cycle();
        check("first word drained occ", 32'(occ), 32'd0);

        // Single word.
        add(1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 2'd1);
        add(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 2'd0);
        // Back-pressure: two words pulled ahead, then rinc stays low.
        add(1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 2'd1);
        add(1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 2'd2);
        add(1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 2'd2);
        add(1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 8'h02, 2'd1);
        add(1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 2'd1);
        add(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h03, 2'd0);
        // Streaming 0x10..0x1F with the consumer always ready.
        for (int w = 0; w < 16; w++)
            add(1'b0, 8'(8'h10 + w), 1'b1, 1'b1, 1'b1, 8'(8'h10 + w), 2'd1);
        add(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h1F, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            rempty     = vecs[i].rempty;
            rdata      = vecs[i].rdata;
            dout_ready = vecs[i].rdy;
            #1;
            check($sformatf("v%0d rinc", i), 32'(rinc), 32'(vecs[i].exp_rinc));
            cycle();
            check($sformatf("v%0d valid", i), 32'(dout_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d dout", i),  32'(dout), 32'(vecs[i].exp_dout));
            check($sformatf("v%0d occ", i),   32'(occ), 32'(vecs[i].exp_occ));
        end

        // Asynchronous reset while full: state clears without an edge.
        rempty     = 1'b0;
        dout_ready = 1'b0;
        rdata      = 8'h55;
        cycle();
        rdata      = 8'h66;
        cycle();
        check("fill occ", 32'(occ), 32'd2);
        #2;
        rrst = 1'b0;
        #1;
        check("async rst occ",   32'(occ), 32'd0);
        check("async rst valid", 32'(dout_valid), 32'd0);
        check("async rst dout",  32'(dout), 32'h00);
        @(negedge rclk);
        rrst  = 1'b1;
        rdata = 8'h77;
        cycle();
        check("after rst dout", 32'(dout), 32'h77);
        check("after rst occ",  32'(occ), 32'd1);
        rempty     = 1'b1;
        dout_ready = 1'b1;
        cycle();
        check("after rst drain valid", 32'(dout_valid), 32'd0);

`ifdef FIFO_RD_PF_STALL_CNT_EN
        // Stall counter: clean reset, load one word, then hold it unaccepted.
        @(negedge rclk);
        rrst = 1'b0;
        #1;
        rrst = 1'b1;
        check("stall rst", 32'(stall_cnt), 32'd0);
        rempty     = 1'b0;
        dout_ready = 1'b0;
        rdata      = 8'h99;
        cycle();
        rempty = 1'b1;
        repeat (5) cycle();
        check("stall cnt 5",       32'(stall_cnt), 32'd5);
        check("stall cnt w2 sat",  32'(stall_cnt2), 32'd3);
        cycle();
        check("stall cnt 6",       32'(stall_cnt), 32'd6);
        check("stall cnt w2 hold", 32'(stall_cnt2), 32'd3);
        dout_ready = 1'b1;
        cycle();
        check("stall cnt stop",    32'(stall_cnt), 32'd6);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
